safe_entry_datapath: RTL and testbench

Code-entry and timing datapath for the digital safe lock. It sits between the debounced keypad and the safe controller FSM. It accepts keypad digits under the FSM's `accept_digit`/`clear_entry` control, reports `done` and `match` back to the FSM, and latches the stored code on `load_code`. It also runs the success/error hold timer, returning `timer_done` after each `start_timer`.

---
 rtl/safe_entry_if.sv | 39 +++
 rtl/safe_entry_datapath.sv | 120 ++++++++++++
 tb/tb_safe_entry_datapath.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/safe_entry_if.sv
`default_nettype none
// ============================================================================
// Module      : safe_entry_if
// Description : Control/status bundle between the safe controller FSM
//               (master) and the code-entry/timer datapath (slave).
//               Master drives keystrokes and FSM commands; slave returns
//               entry status, entry contents and the timer pulse.
// Parameters  : NUM_DIGITS - digits per code, CNT_W - digit counter width.
//               Both must equal the datapath's parameters.
// Revision    : 1.0 - initial release
// ============================================================================
interface safe_entry_if #(
    parameter int NUM_DIGITS = 4,
    parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
);
    logic                    key_valid;
    logic [3:0]              key_digit;
    logic                    clear_entry;
    logic                    accept_digit;
    logic                    load_code;
    logic                    start_timer;
    logic                    done;
    logic                    match;
    logic                    timer_done;
    logic                    key_accepted;
    logic [4*NUM_DIGITS-1:0] entry_value;
    logic [CNT_W-1:0]        entry_count;

    modport master (
        output key_valid, key_digit, clear_entry, accept_digit, load_code, start_timer,
        input  done, match, timer_done, key_accepted, entry_value, entry_count
    );

    modport slave (
        input  key_valid, key_digit, clear_entry, accept_digit, load_code, start_timer,
        output done, match, timer_done, key_accepted, entry_value, entry_count
    );
endinterface
`default_nettype wire

// File: rtl/safe_entry_datapath.sv
`default_nettype none
// ============================================================================
// Module      : safe_entry_datapath
// Description : Keypad code-entry register, stored-code register, compare
//               logic and success/error hold timer for the digital safe.
// Ports       : clk          - clock
//               rst_n        - asynchronous active-low reset
//               bus (slave)  - key_valid/key_digit keystrokes, FSM commands
//                              clear_entry/accept_digit/load_code/start_timer;
//                              status done/match/timer_done/key_accepted,
//                              entry_value (newest digit in [3:0]), entry_count
// Macro       : SAFE_ENTRY_BACKSPACE_EN - key code 4'hB removes the newest
//               digit of an incomplete, non-empty entry.
// Revision    : 1.0 - initial release
// ============================================================================
module safe_entry_datapath #(
    parameter int NUM_DIGITS   = 4,
    parameter int TIMER_CYCLES = 50_000_000,
    parameter int CNT_W        = $clog2(NUM_DIGITS + 1),
    parameter int TMR_W        = $clog2(TIMER_CYCLES)
) (
    input  logic          clk,
    input  logic          rst_n,
    safe_entry_if.slave   bus
);
    localparam int               c_val_w   = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] c_full    = CNT_W'(NUM_DIGITS);
    localparam logic [TMR_W-1:0] c_tmr_top = TMR_W'(TIMER_CYCLES - 1);

    logic [c_val_w-1:0] r_entry_value;
    logic [c_val_w-1:0] r_code;
    logic [CNT_W-1:0]   r_entry_count;
    logic               r_key_accepted;
    logic [TMR_W-1:0]   r_tmr_cnt;
    logic               r_tmr_busy;
    logic               r_timer_done;

    logic               w_full;
    logic               w_key_ok;
    logic               w_take_digit;
    logic               w_take_back;
    logic [c_val_w-1:0] w_shift_in;

    assign w_full   = (r_entry_count == c_full);
    // Common qualifier for any keystroke that may change the entry;
    // clear_entry wins over every same-cycle keystroke.
    assign w_key_ok = bus.key_valid && bus.accept_digit && !bus.clear_entry;

    assign w_take_digit = w_key_ok && (bus.key_digit <= 4'd9) && (r_entry_count < c_full);

    // Size cast drops the oldest digit; also works for NUM_DIGITS == 1.
    assign w_shift_in = c_val_w'({r_entry_value, bus.key_digit});

`ifdef SAFE_ENTRY_BACKSPACE_EN
    // A complete entry is committed, so backspace only acts on 1..N-1 digits.
    assign w_take_back = w_key_ok && (bus.key_digit == 4'hB) &&
                         (r_entry_count != '0) && (r_entry_count < c_full);
`else
    assign w_take_back = 1'b0;
`endif

    // Entry and stored-code registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry_value  <= '0;
            r_entry_count  <= '0;
            r_code         <= '0;
            r_key_accepted <= 1'b0;
        end else begin
            r_key_accepted <= w_take_digit || w_take_back;
            // Uses the pre-clear entry when clear_entry arrives together.
            if (bus.load_code && w_full) begin
                r_code <= r_entry_value;
            end
            if (bus.clear_entry) begin
                r_entry_value <= '0;
                r_entry_count <= '0;
            end else if (w_take_digit) begin
                r_entry_value <= w_shift_in;
                r_entry_count <= r_entry_count + CNT_W'(1);
            end else if (w_take_back) begin
                r_entry_value <= r_entry_value >> 4;
                r_entry_count <= r_entry_count - CNT_W'(1);
            end
        end
    end

    // Hold timer: counts TIMER_CYCLES-1 down to 0, pulse on the edge after 0.
    // A restart reloads the count, so an aborted run never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr_cnt    <= '0;
            r_tmr_busy   <= 1'b0;
            r_timer_done <= 1'b0;
        end else begin
            r_timer_done <= 1'b0;
            if (bus.start_timer) begin
                r_tmr_busy <= 1'b1;
                r_tmr_cnt  <= c_tmr_top;
            end else if (r_tmr_busy) begin
                if (r_tmr_cnt == '0) begin
                    r_tmr_busy   <= 1'b0;
                    r_timer_done <= 1'b1;
                end else begin
                    r_tmr_cnt <= r_tmr_cnt - TMR_W'(1);
                end
            end
        end
    end

    // Status decoded from registers only: no input-to-output path.
    assign bus.done         = w_full;
    assign bus.match        = w_full && (r_entry_value == r_code);
    assign bus.timer_done   = r_timer_done;
    assign bus.key_accepted = r_key_accepted;
    assign bus.entry_value  = r_entry_value;
    assign bus.entry_count  = r_entry_count;

endmodule
`default_nettype wire

// File: tb/tb_safe_entry_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_safe_entry_datapath
// Description : Directed, table-driven bench for safe_entry_datapath with
//               NUM_DIGITS=4 and TIMER_CYCLES=5, plus hand-written timer and
//               reset sequences. Honours SAFE_ENTRY_BACKSPACE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_safe_entry_datapath;
    localparam int ND = 4;
    localparam int TC = 5;
    localparam int CW = 3;
`ifdef SAFE_ENTRY_BACKSPACE_EN
    localparam bit BS = 1'b1;
`else
    localparam bit BS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    safe_entry_if #(.NUM_DIGITS(ND), .CNT_W(CW)) bus ();

    safe_entry_datapath #(
        .NUM_DIGITS   (ND),
        .TIMER_CYCLES (TC),
        .CNT_W        (CW),
        .TMR_W        (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        kv;
        logic [3:0]  kd;
        logic        clr;
        logic        acc;
        logic        ld;
        logic [15:0] ev;
        logic [2:0]  ec;
        logic        dn;
        logic        mt;
        logic        ka;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic kv, input logic [3:0] kd, input logic clr,
                       input logic acc, input logic ld, input logic [15:0] ev,
                       input logic [2:0] ec, input logic dn, input logic mt,
                       input logic ka);
        vec_t v;
        v.kv = kv; v.kd = kd; v.clr = clr; v.acc = acc; v.ld = ld;
        v.ev = ev; v.ec = ec; v.dn = dn; v.mt = mt; v.ka = ka;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic kv, input logic [3:0] kd, input logic clr,
                         input logic acc, input logic ld, input logic st);
        bus.key_valid    = kv;
        bus.key_digit    = kd;
        bus.clear_entry  = clr;
        bus.accept_digit = acc;
        bus.load_code    = ld;
        bus.start_timer  = st;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [15:0] ev,
                             input logic [2:0] ec, input logic dn, input logic mt,
                             input logic ka, input logic td);
        n_vec++;
        if ({bus.entry_value, bus.entry_count, bus.done, bus.match,
             bus.key_accepted, bus.timer_done} !== {ev, ec, dn, mt, ka, td}) begin
            n_err++;
            $display("FAIL %s: got value=%h count=%0d done=%b match=%b ka=%b tdone=%b, want value=%h count=%0d done=%b match=%b ka=%b tdone=%b",
                     name, bus.entry_value, bus.entry_count, bus.done, bus.match,
                     bus.key_accepted, bus.timer_done, ev, ec, dn, mt, ka, td);
        end
    endtask

    task automatic check_td(input string name, input logic td);
        n_vec++;
        if (bus.timer_done !== td) begin
            n_err++;
            $display("FAIL %s: got timer_done=%b, want %b", name, bus.timer_done, td);
        end
    endtask

    initial begin
        // kv  kd    clr acc ld  value     cnt dn mt ka
        add(1, 4'h1, 0, 1, 0, 16'h0001, 1, 0, 0, 1);
        add(1, 4'h2, 0, 1, 0, 16'h0012, 2, 0, 0, 1);
        add(1, 4'h3, 0, 1, 0, 16'h0123, 3, 0, 0, 1);
        add(1, 4'h4, 0, 1, 0, 16'h1234, 4, 1, 0, 1);   // stored code is 0000
        add(0, 4'h0, 0, 1, 0, 16'h1234, 4, 1, 0, 0);
        add(1, 4'h5, 0, 1, 0, 16'h1234, 4, 1, 0, 0);   // fifth key dropped
        add(0, 4'h0, 0, 1, 1, 16'h1234, 4, 1, 1, 0);   // load 1234
        add(0, 4'h0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 4'h1, 0, 1, 0, 16'h0001, 1, 0, 0, 1);
        add(1, 4'h2, 0, 1, 0, 16'h0012, 2, 0, 0, 1);
        add(1, 4'h3, 0, 1, 0, 16'h0123, 3, 0, 0, 1);
        add(1, 4'h4, 0, 1, 0, 16'h1234, 4, 1, 1, 1);   // matches
        add(1, 4'h7, 1, 1, 0, 16'h0000, 0, 0, 0, 0);   // clear beats key
        add(1, 4'hA, 0, 1, 0, 16'h0000, 0, 0, 0, 0);   // non-digit dropped
        add(1, 4'h1, 0, 0, 0, 16'h0000, 0, 0, 0, 0);   // accept_digit low
        add(1, 4'h1, 0, 1, 0, 16'h0001, 1, 0, 0, 1);
        add(1, 4'h2, 0, 1, 0, 16'h0012, 2, 0, 0, 1);
        add(1, 4'h3, 0, 1, 0, 16'h0123, 3, 0, 0, 1);
        add(1, 4'h5, 0, 1, 0, 16'h1235, 4, 1, 0, 1);   // mismatch
        add(0, 4'h0, 1, 1, 1, 16'h0000, 0, 0, 0, 0);   // load pre-clear 1235
        add(1, 4'h9, 0, 1, 0, 16'h0009, 1, 0, 0, 1);
        add(1, 4'h8, 0, 1, 0, 16'h0098, 2, 0, 0, 1);
        add(0, 4'h0, 0, 1, 1, 16'h0098, 2, 0, 0, 0);   // load ignored
        add(0, 4'h0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 4'h1, 0, 1, 0, 16'h0001, 1, 0, 0, 1);
        add(1, 4'h2, 0, 1, 0, 16'h0012, 2, 0, 0, 1);
        add(1, 4'h3, 0, 1, 0, 16'h0123, 3, 0, 0, 1);
        add(1, 4'h5, 0, 1, 0, 16'h1235, 4, 1, 1, 1);   // code is 1235
        add(0, 4'h0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 4'h7, 0, 1, 0, 16'h0007, 1, 0, 0, 1);
        add(1, 4'h8, 0, 1, 0, 16'h0078, 2, 0, 0, 1);
        add(1, 4'hB, 0, 1, 0, BS ? 16'h0007 : 16'h0078, BS ? 3'd1 : 3'd2, 0, 0, BS);
        add(1, 4'h9, 0, 1, 0, BS ? 16'h0079 : 16'h0789, BS ? 3'd2 : 3'd3, 0, 0, 1);
        add(1, 4'h1, 0, 1, 0, BS ? 16'h0791 : 16'h7891, BS ? 3'd3 : 3'd4, !BS, 0, 1);
        add(1, 4'h2, 0, 1, 0, BS ? 16'h7912 : 16'h7891, 4, 1, 0, BS);
        add(1, 4'hB, 0, 1, 0, BS ? 16'h7912 : 16'h7891, 4, 1, 0, 0);   // complete: B ignored
        add(0, 4'h0, 1, 1, 0, 16'h0000, 0, 0, 0, 0);
        add(1, 4'hB, 0, 1, 0, 16'h0000, 0, 0, 0, 0);   // B on empty entry
        add(1, 4'h5, 0, 1, 0, 16'h0005, 1, 0, 0, 1);
        add(1, 4'hB, 1, 1, 0, 16'h0000, 0, 0, 0, 0);   // clear beats backspace

        // Reset state
        drive(0, 4'h0, 0, 0, 0, 0);
        #12;
        check_all("reset_state", 16'h0000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].kv, vecs[i].kd, vecs[i].clr, vecs[i].acc, vecs[i].ld, 1'b0);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].dn,
                      vecs[i].mt, vecs[i].ka, 1'b0);
        end
        drive(0, 4'h0, 0, 0, 0, 0);
        tick();

        // Single timer run: start sampled at edge E, pulse only after E+5
        drive(0, 4'h0, 0, 0, 0, 1);
        tick();
        drive(0, 4'h0, 0, 0, 0, 0);
        check_td("tmr1_k0", 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_td($sformatf("tmr1_k%0d", k), k == 5);
        end

        // Restart two cycles in: only the restarted run pulses, after E+7
        drive(0, 4'h0, 0, 0, 0, 1);
        tick();
        drive(0, 4'h0, 0, 0, 0, 0);
        check_td("tmr2_k0", 1'b0);
        tick();
        check_td("tmr2_k1", 1'b0);
        drive(0, 4'h0, 0, 0, 0, 1);
        tick();
        drive(0, 4'h0, 0, 0, 0, 0);
        check_td("tmr2_k2", 1'b0);
        for (int k = 3; k <= 11; k++) begin
            tick();
            check_td($sformatf("tmr2_k%0d", k), k == 7);
        end

        // Reset mid-entry and mid-timer
        drive(1, 4'h3, 0, 1, 0, 1);
        tick();
        check_all("pre_rst", 16'h0003, 1, 0, 0, 1, 0);
        drive(0, 4'h0, 0, 0, 0, 0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 16'h0000, 0, 0, 0, 0, 0);
        #10 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_td($sformatf("post_rst_k%0d", k), 1'b0);
        end

        // Stored code returned to 0000 by reset
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'h0, 0, 1, 0, 0);
            tick();
        end
        drive(0, 4'h0, 0, 0, 0, 0);
        check_all("code_after_rst", 16'h0000, 4, 1, 1, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
